out_arbiter: RTL and testbench

- Round-robin arbiter sharing the single 7-segment display write port (outval1/outsel/outdisplay of the `out` block) among NREQ requesters, e.g. CPU OUT instruction, debug monitor and trap reporter.
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- Grants are issued as single-cycle outdisplay pulses, optionally rate-limited by a programmable idle gap.
- Sits between the requesters and `out`; its outputs connect directly to `out`.

---
 rtl/out_pkg.sv | 18 +
 rtl/rr_pick.sv | 30 +++
 rtl/out_arbiter.sv | 134 +++++++++++++
 tb/tb_out_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_pkg.sv
// rtl/out_pkg.sv - shared widths, state encoding and pointer helper for the display-port arbiter
package out_pkg;

  localparam int OUT_VAL_W = 16;
  localparam int OUT_SEL_W = 4;
  localparam int MAX_REQ   = 8;

  typedef enum logic {
    ST_IDLE,
    ST_GAP
  } state_e;

  // Next round-robin start position after index p, wrapping at n.
  function automatic logic [2:0] ptr_inc(input logic [2:0] p, input int n);
    return (int'(p) == n - 1) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority encoder over the full flags
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] full,
  input  logic [2:0]      rr_ptr,
  output logic            any,
  output logic [2:0]      winner
);

  // First pass looks at or after rr_ptr; the second pass only matters when
  // every full index lies below rr_ptr, which is the wrap-around case.
  always_comb begin
    any    = 1'b0;
    winner = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && full[i] && (3'(i) >= rr_ptr)) begin
        any    = 1'b1;
        winner = 3'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && full[i]) begin
        any    = 1'b1;
        winner = 3'(i);
      end
    end
  end

endmodule

// File: rtl/out_arbiter.sv
// rtl/out_arbiter.sv - round-robin arbiter sharing the 7-segment display write port among requesters
module out_arbiter
  import out_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GAP  = 0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [OUT_VAL_W*NREQ-1:0] req_val,
  input  logic [OUT_SEL_W*NREQ-1:0] req_sel,
  output logic [OUT_VAL_W-1:0]      outval1,
  output logic [OUT_SEL_W-1:0]      outsel,
  output logic                      outdisplay,
  output logic [2:0]                grant_id,
  output logic                      busy
);

  logic [NREQ-1:0]      full_q, full_d;
  logic [OUT_VAL_W-1:0] val_q [NREQ];
  logic [OUT_VAL_W-1:0] val_d [NREQ];
  logic [OUT_SEL_W-1:0] sel_q [NREQ];
  logic [OUT_SEL_W-1:0] sel_d [NREQ];
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  state_e               state_q, state_d;
  logic [3:0]           gap_cnt_q, gap_cnt_d;
  logic [OUT_VAL_W-1:0] outval1_q, outval1_d;
  logic [OUT_SEL_W-1:0] outsel_q, outsel_d;
  logic                 outdisplay_q, outdisplay_d;
  logic [2:0]           grant_id_q, grant_id_d;

  logic                 pick_any;
  logic [2:0]           pick_winner;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .full   (full_q),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .winner (pick_winner)
  );

  always_comb begin
    full_d       = full_q;
    val_d        = val_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr_q;
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    outval1_d    = outval1_q;
    outsel_d     = outsel_q;
    grant_id_d   = grant_id_q;
    outdisplay_d = 1'b0;

    // Accepts only touch empty buffers and grants only touch full ones, so
    // the two updates below never collide on the same index.
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !full_q[i]) begin
        full_d[i] = 1'b1;
        val_d[i]  = req_val[OUT_VAL_W*i +: OUT_VAL_W];
        sel_d[i]  = req_sel[OUT_SEL_W*i +: OUT_SEL_W];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == pick_winner) begin
              outval1_d = val_q[i];
              outsel_d  = sel_q[i];
              full_d[i] = 1'b0;
            end
          end
          grant_id_d   = pick_winner;
          outdisplay_d = 1'b1;
          rr_ptr_d     = ptr_inc(pick_winner, NREQ);
          if (GAP > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = 4'(GAP);
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - 4'd1;
        if (gap_cnt_q <= 4'd1) begin
          state_d   = ST_IDLE;
          gap_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gap_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q       <= '0;
      rr_ptr_q     <= 3'd0;
      state_q      <= ST_IDLE;
      gap_cnt_q    <= 4'd0;
      outval1_q    <= '0;
      outsel_q     <= '0;
      outdisplay_q <= 1'b0;
      grant_id_q   <= 3'd0;
      for (int i = 0; i < NREQ; i++) begin
        val_q[i] <= '0;
        sel_q[i] <= '0;
      end
    end else begin
      full_q       <= full_d;
      val_q        <= val_d;
      sel_q        <= sel_d;
      rr_ptr_q     <= rr_ptr_d;
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      outval1_q    <= outval1_d;
      outsel_q     <= outsel_d;
      outdisplay_q <= outdisplay_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign req_ready  = ~full_q;
  assign outval1    = outval1_q;
  assign outsel     = outsel_q;
  assign outdisplay = outdisplay_q;
  assign grant_id   = grant_id_q;
  assign busy       = (|full_q) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_out_arbiter.sv
// tb/tb_out_arbiter.sv - scoreboard bench for out_arbiter with GAP=0 and GAP=3 instances
module tb_out_arbiter;

  logic        clock;
  logic        reset_n;

  logic [3:0]  v0, vg;
  logic [63:0] val0, valg;
  logic [15:0] sel0, selg;

  logic [3:0]  rdy0, rdyg;
  logic [15:0] o_val0, o_valg;
  logic [3:0]  o_sel0, o_selg;
  logic        o_disp0, o_dispg;
  logic [2:0]  o_gid0, o_gidg;
  logic        busy0, busyg;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  logic [22:0] sb0[$];
  logic [22:0] sbg[$];
  int          t0_log[$];
  int          tg_log[$];
  logic [2:0]  id_log[$];
  logic [15:0] vl_log[$];
  bit          log_mode0 = 0;

  out_arbiter #(.NREQ(4), .GAP(0)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(v0), .req_ready(rdy0), .req_val(val0), .req_sel(sel0),
    .outval1(o_val0), .outsel(o_sel0), .outdisplay(o_disp0),
    .grant_id(o_gid0), .busy(busy0)
  );

  out_arbiter #(.NREQ(4), .GAP(3)) dutg (
    .clock(clock), .reset_n(reset_n),
    .req_valid(vg), .req_ready(rdyg), .req_val(valg), .req_sel(selg),
    .outval1(o_valg), .outsel(o_selg), .outdisplay(o_dispg),
    .grant_id(o_gidg), .busy(busyg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [22:0] pk(input logic [15:0] v, input logic [3:0] s, input logic [2:0] id);
    return {v, s, id};
  endfunction

  always @(negedge clock) begin
    logic [22:0] e;
    if (o_disp0 === 1'b1) begin
      t0_log.push_back(cyc);
      if (log_mode0) begin
        id_log.push_back(o_gid0);
        vl_log.push_back(o_val0);
      end else if (sb0.size() == 0) begin
        chk_cnt++;
        $display("FAIL pulse0_unexpected got id=%0d val=%h, required no pulse", o_gid0, o_val0);
      end else begin
        e = sb0.pop_front();
        chk_cnt++;
        if ({o_val0, o_sel0, o_gid0} !== e)
          $display("FAIL pulse0 got val=%h sel=%h id=%0d, required val=%h sel=%h id=%0d",
                   o_val0, o_sel0, o_gid0, e[22:7], e[6:3], e[2:0]);
        else pass_cnt++;
      end
    end
    if (o_dispg === 1'b1) begin
      tg_log.push_back(cyc);
      chk_cnt++;
      if (sbg.size() == 0) begin
        $display("FAIL pulseg_unexpected got id=%0d val=%h, required no pulse", o_gidg, o_valg);
      end else begin
        e = sbg.pop_front();
        if ({o_valg, o_selg, o_gidg} !== e)
          $display("FAIL pulseg got val=%h sel=%h id=%0d, required val=%h sel=%h id=%0d",
                   o_valg, o_selg, o_gidg, e[22:7], e[6:3], e[2:0]);
        else pass_cnt++;
      end
    end
  end

  task automatic do_reset();
    v0 = '0; vg = '0; val0 = '0; valg = '0; sel0 = '0; selg = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (20) begin
      @(negedge clock);
      chk_cnt++;
      if ({rdy0, o_disp0, o_val0, o_sel0, o_gid0, busy0} !== {4'hf, 1'b0, 16'h0, 4'h0, 3'd0, 1'b0})
        $display("FAIL reset_idle got rdy=%b disp=%b val=%h sel=%h id=%0d busy=%b, required 1111/0/0000/0/0/0",
                 rdy0, o_disp0, o_val0, o_sel0, o_gid0, busy0);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    do_reset();
    @(posedge clock); #1;
    val0[47:32] = 16'hBEEF; sel0[11:8] = 4'h5; v0 = 4'b0100;
    sb0.push_back(pk(16'hBEEF, 4'h5, 3'd2));
    @(posedge clock); #1 v0 = '0;
    @(negedge clock);
    chk_cnt++;
    if ({rdy0, o_disp0} !== {4'b1011, 1'b0})
      $display("FAIL single_accept got rdy=%b disp=%b, required 1011/0", rdy0, o_disp0);
    else pass_cnt++;
    @(negedge clock);
    chk_cnt++;
    if ({rdy0, o_disp0} !== {4'b1111, 1'b1})
      $display("FAIL single_grant got rdy=%b disp=%b, required 1111/1", rdy0, o_disp0);
    else pass_cnt++;
    @(negedge clock);
    chk_cnt++;
    if ({o_disp0, o_val0, o_sel0, o_gid0} !== {1'b0, 16'hBEEF, 4'h5, 3'd2})
      $display("FAIL single_hold got disp=%b val=%h sel=%h id=%0d, required 0/beef/5/2",
               o_disp0, o_val0, o_sel0, o_gid0);
    else pass_cnt++;
  endtask

  task automatic test_all_four();
    logic [15:0] vals [4];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
    do_reset();
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      val0[16*i +: 16] = vals[i];
      sel0[4*i +: 4]   = 4'(i + 8);
      sb0.push_back(pk(vals[i], 4'(i + 8), 3'(i)));
    end
    v0 = 4'hf;
    @(posedge clock); #1 v0 = '0;
    @(negedge clock);
    chk_cnt++;
    if (o_disp0 !== 1'b0) $display("FAIL all4_no_bypass got disp=%b, required 0", o_disp0);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk_cnt++;
      if (o_disp0 !== 1'b1) $display("FAIL all4_pulse%0d got disp=%b, required 1", k, o_disp0);
      else pass_cnt++;
    end
    @(negedge clock);
    chk_cnt++;
    if ({o_disp0, busy0} !== 2'b00) $display("FAIL all4_done got disp=%b busy=%b, required 0/0", o_disp0, busy0);
    else pass_cnt++;
    // Pointer back at 0 means requester 0 beats requester 3.
    @(posedge clock); #1;
    val0[15:0] = 16'hA0A0; sel0[3:0] = 4'h1;
    val0[63:48] = 16'hA3A3; sel0[15:12] = 4'h1;
    sb0.push_back(pk(16'hA0A0, 4'h1, 3'd0));
    sb0.push_back(pk(16'hA3A3, 4'h1, 3'd3));
    v0 = 4'b1001;
    @(posedge clock); #1 v0 = '0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_gap();
    do_reset();
    tg_log.delete();
    @(posedge clock); #1;
    valg[15:0] = 16'h0A0A; selg[3:0] = 4'h2;
    valg[31:16] = 16'h1B1B; selg[7:4] = 4'h3;
    sbg.push_back(pk(16'h0A0A, 4'h2, 3'd0));
    sbg.push_back(pk(16'h1B1B, 4'h3, 3'd1));
    sbg.push_back(pk(16'h3C3C, 4'h7, 3'd3));
    vg = 4'b0011;
    @(posedge clock); #1 vg = '0;
    @(posedge clock); #1;
    valg[63:48] = 16'h3C3C; selg[15:12] = 4'h7; vg = 4'b1000;
    @(posedge clock); #1 vg = '0;
    repeat (14) @(negedge clock);
    chk_cnt++;
    if (tg_log.size() != 3) $display("FAIL gap_count got %0d pulses, required 3", tg_log.size());
    else begin
      pass_cnt++;
      chk_cnt++;
      if (tg_log[1] - tg_log[0] != 4) $display("FAIL gap_sep01 got %0d, required 4", tg_log[1] - tg_log[0]);
      else pass_cnt++;
      chk_cnt++;
      if (tg_log[2] - tg_log[1] != 4) $display("FAIL gap_sep13 got %0d, required 4", tg_log[2] - tg_log[1]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (busyg !== 1'b0) $display("FAIL gap_idle_busy got %b, required 0", busyg);
    else pass_cnt++;
  endtask

  task automatic test_starve();
    int pos3;
    do_reset();
    id_log.delete(); vl_log.delete();
    log_mode0 = 1;
    @(posedge clock); #1;
    val0[15:0] = 16'hA000; val0[63:48] = 16'hD003;
    v0 = 4'b1001;
    @(posedge clock); #1 v0 = 4'b0001;
    repeat (10) @(posedge clock);
    #1 v0 = '0;
    repeat (4) @(negedge clock);
    log_mode0 = 0;
    pos3 = -1;
    for (int k = 0; k < id_log.size(); k++)
      if (pos3 < 0 && id_log[k] == 3'd3) pos3 = k;
    chk_cnt++;
    if (pos3 < 0 || pos3 > 3) $display("FAIL starve_bound got grant position %0d, required 0..3", pos3);
    else pass_cnt++;
    chk_cnt++;
    if (id_log.size() < 4) $display("FAIL starve_count got %0d grants, required >=4", id_log.size());
    else pass_cnt++;
    for (int k = 0; k < id_log.size(); k++) begin
      chk_cnt++;
      if (!((id_log[k] == 3'd0 && vl_log[k] == 16'hA000) || (id_log[k] == 3'd3 && vl_log[k] == 16'hD003)))
        $display("FAIL starve_val%0d got id=%0d val=%h, required 0/a000 or 3/d003", k, id_log[k], vl_log[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int n_before;
    do_reset();
    @(posedge clock); #1;
    val0[15:0] = 16'h5550; val0[31:16] = 16'h5551; val0[63:48] = 16'h5553;
    v0 = 4'b1011;
    @(posedge clock); #1 v0 = '0;
    @(posedge clock); #2;
    chk_cnt++;
    if ({o_disp0, o_val0, o_gid0, rdy0} !== {1'b1, 16'h5550, 3'd0, 4'b0101})
      $display("FAIL mid_pulse got disp=%b val=%h id=%0d rdy=%b, required 1/5550/0/0101",
               o_disp0, o_val0, o_gid0, rdy0);
    else pass_cnt++;
    reset_n = 1'b0;
    #1;
    chk_cnt++;
    if ({o_disp0, rdy0} !== {1'b0, 4'hf})
      $display("FAIL mid_cut got disp=%b rdy=%b, required 0/1111", o_disp0, rdy0);
    else pass_cnt++;
    n_before = t0_log.size();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk_cnt++;
    if ({rdy0, busy0} !== {4'hf, 1'b0} || t0_log.size() != n_before)
      $display("FAIL mid_after got rdy=%b busy=%b extra_pulses=%0d, required 1111/0/0",
               rdy0, busy0, t0_log.size() - n_before);
    else pass_cnt++;
  endtask

  initial begin
    reset_n = 1'b0;
    v0 = '0; vg = '0; val0 = '0; valg = '0; sel0 = '0; selg = '0;
    test_reset();
    test_single();
    test_all_four();
    test_gap();
    test_starve();
    test_reset_mid();
    repeat (4) @(negedge clock);
    chk_cnt++;
    if (sb0.size() != 0 || sbg.size() != 0)
      $display("FAIL scoreboard_drain got %0d/%0d pending, required 0/0", sb0.size(), sbg.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
